// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: {c_out, s} = a + b + c_in, CHUNK bits per clock, plus a signed-overflow flag.
// Latency: start accepted at edge k gives done and a valid result after edge k+NCHUNK.
// Backpressure: start is ignored while busy. Optional subtract mode is enabled by SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject geometries where the chunks do not tile the operand exactly.
  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
      $error("seq_chunk_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, work, work_nx;
  logic [CHUNK-1:0] ca, cb, csum;
  logic             ccy, msb_cin, last;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Operand conditioning at capture: subtraction is a + ~b + !c_in.
  always_comb begin
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = c_in ^ sub;
`else
    b_eff   = b;
    cin_eff = c_in;
`endif
  end

  // Narrow chunk adder plus the carry into the chunk MSB for overflow detection.
  always_comb begin
    ca      = a_q[int'(idx)*CHUNK +: CHUNK];
    cb      = b_q[int'(idx)*CHUNK +: CHUNK];
    {ccy, csum} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];
    work_nx = work;
    work_nx[int'(idx)*CHUNK +: CHUNK] = csum;
    last    = (idx == IDXW'(NCHUNK - 1));
  end

  // Next-state logic and busy indication.
  always_comb begin
    state_nx = state;
    busy     = (state == RUN);
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: capture operands, accumulate chunks, publish only completed results.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_q   <= a;
        b_q   <= b_eff;
        carry <= cin_eff;
        idx   <= '0;
      end else if (state == RUN) begin
        work  <= work_nx;
        carry <= ccy;
        idx   <= idx + IDXW'(1);
        if (last) begin
          s     <= work_nx;
          c_out <= ccy;
          ovf   <= msb_cin ^ ccy;
          done  <= 1'b1;
          idx   <= '0;
        end
      end
    end
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder. Computes an unsigned WIDTH-bit sum with carry in and carry out, plus a signed-overflow flag, CHUNK bits per clock. A single carry register links the chunks, so a wide add needs only a narrow adder. It is the sequential successor of the fixed 4-bit ripple adder. It serves datapaths that trade latency for area and talk to a controller over a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and sum width in bits; must be at least 1.
CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0, otherwise elaboration fails with an error.
NCHUNK, WIDTH/CHUNK, derived and not overridable; cycles per operation.

Ports:
clk    input   1      clock; all state changes on the rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request a new operation; honoured only while busy=0
a      input   WIDTH  operand A; sampled on the accepted start edge
b      input   WIDTH  operand B; sampled on the accepted start edge
c_in   input   1      carry in; sampled on the accepted start edge
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse: result valid
s      output  WIDTH  sum; registered
c_out  output  1      carry out of the MSB; registered
ovf    output  1      signed overflow, equal to (carry into MSB) XOR (carry out of MSB); registered

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, s=0, c_out=0, ovf=0; internal index, carry and operand registers cleared. Reset wins over start and aborts any operation in progress; nothing partial reaches the outputs.
- FSM has two states, IDLE and RUN.
  - IDLE: start=1 at edge k captures a, b, c_in into internal registers, sets idx=0, carry=c_in, state=RUN, busy=1.
  - RUN: each edge adds chunk idx, i.e. bits [idx*CHUNK +: CHUNK] of the captured A and B plus the carry register. The chunk sum goes to a working register and the carry register is updated. idx then increments.
  - RUN, last chunk (idx=NCHUNK-1): working sum is copied to s, final carry to c_out, and ovf is computed. done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: start accepted at edge k gives done=1 and a valid result after edge k+NCHUNK. busy is high after edges k through k+NCHUNK-1. When CHUNK=WIDTH, the latency is 1 cycle.
- start while busy=1 is ignored; operands are not re-sampled and the result is unaffected.
- start=1 in the cycle where done=1 is accepted, because busy=0 then. This allows back-to-back operations with one operation per NCHUNK+1 cycles.
- s, c_out and ovf hold their last completed result until the next completion or reset; they never show partial sums.
- Input changes on a, b and c_in after the start edge have no effect.
- Arithmetic: result is {c_out, s} = a + b + c_in, exact and unsigned. Wrap-around is modulo 2^WIDTH, with the carry reported on c_out.

Optional Feature:
Macro: SEQ_CHUNK_ADDER_SUB_EN.
- Defined: adds port "sub", an input of width 1, sampled with the operands.
  - sub=1 computes s = a - b - c_in modulo 2^WIDTH, implemented as a + ~b + !c_in.
  - In subtract mode c_out=1 means no borrow. ovf is the signed-subtract overflow, using the same MSB carry-XOR rule.
  - sub=0 behaves exactly as the add-only build.
- Not defined: port "sub" is absent and the block is add-only; no other behaviour changes.

Test Plan:
1. Reset mid-operation (WIDTH=16, CHUNK=4): assert rst at edge k+2 → busy=0, done never pulses, s=0, c_out=0, ovf=0. Next start completes normally.
2. Full carry ripple (WIDTH=16, CHUNK=4): a=0xFFFF, b=0x0001, c_in=0 → after 4 edges done=1, s=0x0000, c_out=1, ovf=0. busy is high for exactly 4 cycles.
3. Signed overflow and start-while-busy (WIDTH=16, CHUNK=4): a=0x7FFF, b=0x0001, c_in=1 → s=0x8001, c_out=0, ovf=1. Pulsing start with different operands while busy leaves the result unchanged.
4. Back-to-back (WIDTH=16, CHUNK=4): start held high continuously with a=0x1234, b=0x4321, c_in=0, then a=0x00FF, b=0x0F01, c_in=1. Expected results are s=0x5555, then s=0x1001, c_out=0. Done pulses are 5 cycles apart.
5. Degenerate geometry: CHUNK=WIDTH=8 with a=0x80, b=0x80 → done 1 cycle after start, s=0x00, c_out=1, ovf=1. Elaborating WIDTH=10, CHUNK=4 must fail.
6. With SEQ_CHUNK_ADDER_SUB_EN, sub=1 (WIDTH=16, CHUNK=4):
   - a=0x0005, b=0x0007, c_in=0 → s=0xFFFE, c_out=0.
   - a=0x8000, b=0x0001, c_in=0 → s=0x7FFF, c_out=1, ovf=1.
